crc_frame_serializer: RTL

Byte-to-bit framing stage that sits directly upstream of `crc32_mpeg2`. It accepts frames of bytes over a valid/ready stream and serializes each byte MSB-first onto a 1-bit output. It drives the internal `crc32_mpeg2` instance with exactly those bits, then appends the 32-bit CRC-32/MPEG-2 (MSB-first, no final XOR) to close the frame. A configurable idle gap separates frames.

---
 rtl/frame_pkg.sv | 30 +++
 rtl/crc_frame_serializer_crc.sv | 33 +++
 rtl/crc_frame_serializer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared types and constants for the CRC-32/MPEG-2 frame serializer.
package frame_pkg;

  localparam int unsigned CRC_W     = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned CTR_W     = 8;
  localparam int unsigned CRC_IDX_W = 5;

  localparam logic [CRC_W-1:0] CRC_MPEG2_POLY  = 32'h04C1_1DB7;
  localparam logic [CRC_W-1:0] CRC_MPEG2_INIT  = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC_MPEG2_CHECK = 32'h0376_E6E7;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    WAIT,
    CRC,
    GAP
  } state_e;

  // One MSB-first shift of the CRC register with a single input bit.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic din);
    logic fb;
    fb = crc[CRC_W-1] ^ din;
    crc_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_MPEG2_POLY : '0);
  endfunction

endpackage

// File: rtl/crc_frame_serializer_crc.sv
// Bit-serial CRC-32/MPEG-2 engine: MSB-first, init all-ones, no final XOR.
module crc32_mpeg2
  import frame_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic [CRC_W-1:0] dout
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (din_valid) begin
      crc_d = crc_step(crc_q, din);
    end
  end

  // Synchronous clear: rst is a decoded state, so keep it off the async pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_MPEG2_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign dout = crc_q;

endmodule

// File: rtl/crc_frame_serializer.sv
// Serializes a byte stream MSB-first and closes each frame with its
// CRC-32/MPEG-2, followed by a programmable idle gap.
module crc_frame_serializer
  import frame_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              bit_sof,
  output logic              bit_eof,
  output logic              busy
);

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTR_W-1:0]       ctr_q, ctr_d;
  logic [BYTE_W-1:0]      byte_q, byte_d;
  logic                   last_q, last_d;
  logic                   first_q, first_d;

  logic                   ready_c;
  logic                   accept_c;
  logic                   crc_rst;
  logic                   crc_din_valid;
  logic [CRC_W-1:0]       crc_dout;
  logic [CRC_IDX_W-1:0]   crc_idx;

  // CRC cycle k presents bit 31-k.
  assign crc_idx = CRC_IDX_W'(CRC_W - 1) - ctr_q[CRC_IDX_W-1:0];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ctr_d         = ctr_q;
    byte_d        = byte_q;
    last_d        = last_q;
    first_d       = first_q;
    ready_c       = 1'b0;
    bit_valid     = 1'b0;
    bit_out       = 1'b0;
    bit_sof       = 1'b0;
    bit_eof       = 1'b0;
    crc_din_valid = 1'b0;

    unique case (state_q)
      IDLE: ready_c = 1'b1;
      DATA: begin
        bit_valid     = 1'b1;
        bit_out       = byte_q[cnt_q];
        bit_sof       = first_q && (cnt_q == BIT_CNT_W'(BYTE_W - 1));
        crc_din_valid = 1'b1;
        cnt_d         = cnt_q - BIT_CNT_W'(1);
        if (cnt_q == '0) begin
          if (last_q) begin
            state_d = CRC;
            ctr_d   = '0;
          end else begin
            ready_c = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: ready_c = 1'b1;
      CRC: begin
        bit_valid = 1'b1;
        bit_out   = crc_dout[crc_idx];
        ctr_d     = ctr_q + CTR_W'(1);
        if (ctr_q == CTR_W'(CRC_W - 1)) begin
          bit_eof = 1'b1;
          ctr_d   = '0;
          state_d = (GAP_CYCLES == 32'd0) ? IDLE : GAP;
        end
      end
      GAP: begin
        ctr_d = ctr_q + CTR_W'(1);
        if (ctr_q == CTR_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any accepted byte restarts the bit counter, so DATA continues without a bubble.
    accept_c = ready_c && s_valid;
    if (accept_c) begin
      byte_d  = s_data;
      last_d  = s_last;
      cnt_d   = BIT_CNT_W'(BYTE_W - 1);
      first_d = (state_q == IDLE);
      state_d = DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctr_q   <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctr_q   <= ctr_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  assign s_ready = ready_c && !rst;
  assign busy    = (state_q != IDLE);
  assign crc_rst = rst || (state_q == IDLE);

  crc32_mpeg2 u_crc (
    .clk       (clk),
    .rst       (crc_rst),
    .din       (bit_out),
    .din_valid (crc_din_valid),
    .dout      (crc_dout)
  );

endmodule
